// File: rtl/pipeline_pkg.sv
// pipeline_pkg: widths, control-bit positions and memory-stage state shared by the pipeline.
package pipeline_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int REG_W = 3;
  localparam int TIMEOUT_CYCLES = 15;
  localparam int MEM_READ = 0;
  localparam int MEM_WRITE = 1;
  localparam int WB_SRC = 0;
  localparam int REG_WRITE = 1;
  typedef enum logic {IDLE, ACCESS} mem_state_t;
endpackage

// File: rtl/mem_timeout_counter.sv
// mem_timeout_counter: counts enabled cycles and flags the last one allowed before a timeout.
module mem_timeout_counter
  import pipeline_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  // Fires during the LIMIT-th enabled cycle so the request is held exactly LIMIT cycles.
  assign expired = en & (cnt_q == CW'(LIMIT - 1));
endmodule

// File: rtl/mem_stage.sv
// mem_stage: load/store stage between EXE and WB using a req/ack data memory with a timeout.
module mem_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W = pipeline_pkg::DATA_W,
  parameter int ADDR_W = pipeline_pkg::ADDR_W,
  parameter int REG_W = pipeline_pkg::REG_W,
  parameter int TIMEOUT_CYCLES = pipeline_pkg::TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [1:0]        mem_signals,
  input  logic [1:0]        wb_signals,
  input  logic [REG_W-1:0]  rd,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_reg_write,
  output logic              mem_error
);
  mem_state_t state_q, state_d;
  logic we_q, we_d;
  logic [DATA_W-1:0] alu_q, alu_d, wdata_q, wdata_d;
  logic [REG_W-1:0] rd_q, rd_d;
  logic [1:0] wb_q, wb_d;
  logic out_valid_q, out_valid_d, out_reg_write_q, out_reg_write_d, mem_error_q, mem_error_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic [REG_W-1:0] out_rd_q, out_rd_d;
  logic access, accept, no_access, expired;
  assign access = state_q == ACCESS;
  assign in_ready = ~access;
  assign accept = in_valid & in_ready;
  assign stall = in_valid & ~in_ready;
  // Both "no memory op" (00) and "illegal" (11) complete without touching memory.
  assign no_access = mem_signals[MEM_READ] ~^ mem_signals[MEM_WRITE];
  mem_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk), .rst_n(rst_n), .clr(~access | dmem_ack), .en(access), .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    we_d = we_q;
    alu_d = alu_q;
    wdata_d = wdata_q;
    rd_d = rd_q;
    wb_d = wb_q;
    out_valid_d = 1'b0;
    mem_error_d = 1'b0;
    out_result_d = out_result_q;
    out_rd_d = out_rd_q;
    out_reg_write_d = out_reg_write_q;
    if (accept && no_access) begin
      out_valid_d = 1'b1;
      out_result_d = mem_signals[MEM_READ] ? '0 : alu_result;
      out_rd_d = rd;
      out_reg_write_d = ~mem_signals[MEM_READ] & wb_signals[REG_WRITE];
      mem_error_d = mem_signals[MEM_READ];
    end else if (accept) begin
      state_d = ACCESS;
      we_d = mem_signals[MEM_WRITE];
      alu_d = alu_result;
      wdata_d = store_data;
      rd_d = rd;
      wb_d = wb_signals;
    end else if (access && (dmem_ack || expired)) begin
      state_d = IDLE;
      out_valid_d = 1'b1;
      out_rd_d = rd_q;
      out_result_d = ~dmem_ack ? '0 : (~we_q & wb_q[WB_SRC]) ? dmem_rdata : alu_q;
      out_reg_write_d = dmem_ack & wb_q[REG_WRITE];
      mem_error_d = ~dmem_ack;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      alu_q <= '0;
      wdata_q <= '0;
      rd_q <= '0;
      wb_q <= '0;
      out_valid_q <= 1'b0;
      out_result_q <= '0;
      out_rd_q <= '0;
      out_reg_write_q <= 1'b0;
      mem_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      alu_q <= alu_d;
      wdata_q <= wdata_d;
      rd_q <= rd_d;
      wb_q <= wb_d;
      out_valid_q <= out_valid_d;
      out_result_q <= out_result_d;
      out_rd_q <= out_rd_d;
      out_reg_write_q <= out_reg_write_d;
      mem_error_q <= mem_error_d;
    end
  assign dmem_req = access;
  assign dmem_we = we_q;
  assign dmem_addr = alu_q[ADDR_W-1:0];
  assign dmem_wdata = wdata_q;
  assign out_valid = out_valid_q;
  assign out_result = out_result_q;
  assign out_rd = out_rd_q;
  assign out_reg_write = out_reg_write_q;
  assign mem_error = mem_error_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and random transactions checked against a rule-level model of the stage.
module tb_mem_stage;
  localparam int TMO = 15;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, stall, dmem_req, dmem_we, dmem_ack = 1'b0;
  logic out_valid, out_reg_write, mem_error;
  logic [15:0] alu_result = '0, store_data = '0, dmem_addr, dmem_wdata, dmem_rdata = '0, out_result;
  logic [1:0] mem_signals = '0, wb_signals = '0;
  logic [2:0] rd = '0, out_rd;
  int n_checks = 0, n_errors = 0;
  mem_stage #(.DATA_W(16), .ADDR_W(16), .REG_W(3), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .store_data(store_data), .mem_signals(mem_signals),
    .wb_signals(wb_signals), .rd(rd), .stall(stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .out_valid(out_valid),
    .out_result(out_result), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .mem_error(mem_error)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // One instruction from EXE; lat = ack after that many req cycles, 0 = never ack.
  task automatic do_op(input logic [1:0] mem, input logic [1:0] wb, input logic [15:0] alu,
                       input logic [15:0] sd, input logic [15:0] rdv, input logic [2:0] r,
                       input int lat);
    bit is_mem, tmo, bad;
    int lim;
    logic [15:0] er;
    logic ewr;
    is_mem = (mem == 2'b01) || (mem == 2'b10);
    tmo = is_mem && lat == 0;
    bad = tmo || mem == 2'b11;
    lim = lat == 0 ? TMO : lat;
    er = bad ? 16'h0 : (mem == 2'b01 && wb[0]) ? rdv : alu;
    ewr = !bad && wb[1];
    in_valid = 1'b1; mem_signals = mem; wb_signals = wb; alu_result = alu; store_data = sd; rd = r;
    @(negedge clk);
    check("in_ready", in_ready, 1);
    check("stall_idle", stall, 0);
    @(posedge clk); #1;
    if (!is_mem) in_valid = 1'b0;
    else
      for (int k = 1; k <= lim; k++) begin
        alu_result = $urandom; store_data = $urandom; dmem_rdata = ~rdv;
        @(negedge clk);
        check("req", dmem_req, 1);
        check("stall", stall, 1);
        check("we", dmem_we, mem == 2'b10);
        check("addr", dmem_addr, alu);
        check("wdata", dmem_wdata, sd);
        if (k == lat) begin dmem_ack = 1'b1; dmem_rdata = rdv; end
        @(posedge clk); #1;
        dmem_ack = 1'b0; dmem_rdata = ~rdv;
      end
    in_valid = 1'b0;
    @(negedge clk);
    check("req_off", dmem_req, 0);
    check("in_ready_back", in_ready, 1);
    check("out_valid", out_valid, 1);
    check("out_result", out_result, er);
    check("out_rd", out_rd, r);
    check("out_reg_write", out_reg_write, ewr);
    check("mem_error", mem_error, bad);
    @(posedge clk); #1;
    @(negedge clk);
    check("valid_pulse", out_valid, 0);
    check("error_pulse", mem_error, 0);
    check("hold_result", out_result, er);
    @(posedge clk); #1;
  endtask
  initial begin
    logic [15:0] pa, a;
    logic [2:0] pr, r;
    logic pw, w, have;
    int sel;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", dmem_req, 0);
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_result", out_result, 0);
    check("rst_err", mem_error, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(2'b00, 2'b10, 16'h0014, 16'h0, 16'h0, 3'd3, 1);
    do_op(2'b01, 2'b11, 16'h0020, 16'h0, 16'hBEEF, 3'd5, 3);
    do_op(2'b10, 2'b00, 16'h0010, 16'hFFF6, 16'h1234, 3'd2, 2);
    do_op(2'b01, 2'b11, 16'h0040, 16'h0, 16'h5555, 3'd1, 0);
    do_op(2'b11, 2'b11, 16'h0033, 16'h7, 16'h0, 3'd6, 1);
    do_op(2'b01, 2'b11, 16'h0044, 16'h0, 16'hCAFE, 3'd4, TMO);
    do_op(2'b01, 2'b10, 16'h0046, 16'h0, 16'hD00D, 3'd7, 1);
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check("stray_ack", out_valid, 0);
    @(posedge clk); #1;
    have = 1'b0; pa = '0; pr = '0; pw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a = $urandom; r = $urandom; w = $urandom;
      in_valid = 1'b1; mem_signals = 2'b00; wb_signals = {w, 1'b1}; alu_result = a; rd = r;
      @(negedge clk);
      check("b2b_ready", in_ready, 1);
      if (have) begin
        check("b2b_valid", out_valid, 1);
        check("b2b_result", out_result, pa);
        check("b2b_rd", out_rd, pr);
        check("b2b_wr", out_reg_write, pw);
      end
      pa = a; pr = r; pw = w; have = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_last", out_result, pa);
    @(posedge clk); #1;
    in_valid = 1'b1; mem_signals = 2'b01; wb_signals = 2'b11; alu_result = 16'h0099; rd = 3'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_req", dmem_req, 0);
    check("arst_ready", in_ready, 1);
    check("arst_addr", dmem_addr, 0);
    check("arst_valid", out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_valid", out_valid, 0);
      check("post_rst_req", dmem_req, 0);
      @(posedge clk); #1;
    end
    do_op(2'b01, 2'b11, 16'h0099, 16'h0, 16'hABCD, 3'd2, 2);
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      do_op(2'($urandom_range(0, 3)), 2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            3'($urandom), sel == 0 ? 0 : sel == 1 ? TMO : $urandom_range(1, 4));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
